// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap-state holder for the RV32 core.
// Captures mepc/mcause on traps, stacks MIE, serves Zicsr accesses and runs mcycle/minstret.
module csr_trap_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        exception,
   input  logic        interrupt,
   input  logic [31:0] exception_pc,
   input  logic [31:0] exception_cause,
   input  logic        mret,
   output logic [31:0] mret_target,
   input  logic        csr_en,
   input  logic [1:0]  csr_op,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        csr_illegal,
   input  logic        instret,
   input  logic        ext_irq,
   input  logic        timer_irq,
   output logic        irq_pending,
   output logic        interrupt_en,
   output logic [1:0]  mtvec_mode,
   output logic [31:0] mtvec_base
);

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MISA      = 12'h301;
   localparam logic [11:0] A_MIE       = 12'h304;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MTVAL     = 12'h343;
   localparam logic [11:0] A_MIP       = 12'h344;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_CYCLE     = 12'hC00;
   localparam logic [11:0] A_INSTRET   = 12'hC02;
   localparam logic [11:0] A_CYCLEH    = 12'hC80;
   localparam logic [11:0] A_INSTRETH  = 12'hC82;
   localparam logic [11:0] A_MHARTID   = 12'hF14;

   logic        mstatus_mie_q, mstatus_mie_d;
   logic        mstatus_mpie_q, mstatus_mpie_d;
   logic [31:0] mie_q, mie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mtval_q, mtval_d;
   logic [63:0] mcycle_q, mcycle_d;
   logic [63:0] minstret_q, minstret_d;

   logic [31:0] mip;
   logic [31:0] mstatus_rd;
   logic        known;
   logic        csr_we;
   logic        commit;
   logic [31:0] wval;
   logic        unused_ok;

   assign unused_ok = ^{exception_pc[1:0], exception_cause[31]};

   assign mip        = {20'b0, ext_irq, 3'b0, timer_irq, 7'b0};
   assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

   always_comb begin
      known     = 1'b1;
      csr_rdata = 32'b0;
      case (csr_addr)
         A_MSTATUS:              csr_rdata = mstatus_rd;
         A_MISA:                 csr_rdata = 32'h4000_0100;
         A_MIE:                  csr_rdata = mie_q;
         A_MTVEC:                csr_rdata = mtvec_q;
         A_MSCRATCH:             csr_rdata = mscratch_q;
         A_MEPC:                 csr_rdata = mepc_q;
         A_MCAUSE:               csr_rdata = mcause_q;
         A_MTVAL:                csr_rdata = mtval_q;
         A_MIP:                  csr_rdata = mip;
         A_MCYCLE, A_CYCLE:      csr_rdata = mcycle_q[31:0];
         A_MCYCLEH, A_CYCLEH:    csr_rdata = mcycle_q[63:32];
         A_MINSTRET, A_INSTRET:  csr_rdata = minstret_q[31:0];
         A_MINSTRETH, A_INSTRETH: csr_rdata = minstret_q[63:32];
         A_MHARTID:              csr_rdata = 32'b0;
         default:                known = 1'b0;
      endcase
   end

   // set/clear with a zero mask is a pure read, so it may target read-only CSRs
   assign csr_we      = csr_en & ((csr_op == 2'b01) | (csr_op[1] & (|csr_wdata)));
   assign csr_illegal = csr_en & (~known | (csr_we & (csr_addr[11:10] == 2'b11)));
   assign commit      = csr_we & ~csr_illegal;

   always_comb begin
      case (csr_op)
         2'b01:   wval = csr_wdata;
         2'b10:   wval = csr_rdata | csr_wdata;
         2'b11:   wval = csr_rdata & ~csr_wdata;
         default: wval = csr_rdata;
      endcase
   end

   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_d          = mie_q;
      mtvec_d        = mtvec_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mtval_d        = mtval_q;
      mcycle_d       = mcycle_q + 64'd1;
      minstret_d     = minstret_q + {63'b0, instret};

      if (exception) begin
         mepc_d         = {exception_pc[31:2], 2'b00};
         mcause_d       = {interrupt, exception_cause[30:0]};
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (mret) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end else if (commit && csr_addr == A_MSTATUS) begin
         mstatus_mie_d  = wval[3];
         mstatus_mpie_d = wval[7];
      end

      if (commit && !exception) begin
         if (csr_addr == A_MEPC)   mepc_d   = {wval[31:2], 2'b00};
         if (csr_addr == A_MCAUSE) mcause_d = wval;
      end

      if (commit) begin
         case (csr_addr)
            A_MIE:       mie_d      = wval & 32'h0000_0880;
            // reserved modes 2/3 leave the mode field untouched
            A_MTVEC:     mtvec_d    = {wval[31:2], wval[1] ? mtvec_q[1:0] : wval[1:0]};
            A_MSCRATCH:  mscratch_d = wval;
            A_MTVAL:     mtval_d    = wval;
            A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wval};
            A_MCYCLEH:   mcycle_d   = {wval, mcycle_q[31:0]};
            A_MINSTRET:  minstret_d = {minstret_q[63:32], wval};
            A_MINSTRETH: minstret_d = {wval, minstret_q[31:0]};
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= 32'b0;
         mtvec_q        <= 32'b0;
         mscratch_q     <= 32'b0;
         mepc_q         <= 32'b0;
         mcause_q       <= 32'b0;
         mtval_q        <= 32'b0;
         mcycle_q       <= 64'b0;
         minstret_q     <= 64'b0;
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_q          <= mie_d;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mtval_q        <= mtval_d;
         mcycle_q       <= mcycle_d;
         minstret_q     <= minstret_d;
      end
   end

   assign mret_target  = mepc_q;
   assign interrupt_en = mstatus_mie_q;
   assign mtvec_mode   = mtvec_q[1:0];
   assign mtvec_base   = {mtvec_q[31:2], 2'b00};
   assign irq_pending  = mstatus_mie_q & (|(mie_q & mip));

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: a per-cycle vector table plus hand sequences
// for counters, wrap-around and reset priority.
module tb_csr_trap_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        exception, interrupt, mret, csr_en, instret, ext_irq, timer_irq;
   logic [31:0] exception_pc, exception_cause, csr_wdata;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] mret_target, csr_rdata, mtvec_base;
   logic        csr_illegal, irq_pending, interrupt_en;
   logic [1:0]  mtvec_mode;

   int n_chk = 0;
   int n_fail = 0;

   csr_trap_unit dut (
      .clk(clk), .rst(rst), .exception(exception), .interrupt(interrupt),
      .exception_pc(exception_pc), .exception_cause(exception_cause), .mret(mret),
      .mret_target(mret_target), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
      .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
      .instret(instret), .ext_irq(ext_irq), .timer_irq(timer_irq),
      .irq_pending(irq_pending), .interrupt_en(interrupt_en),
      .mtvec_mode(mtvec_mode), .mtvec_base(mtvec_base)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        crd;
      logic [31:0] erd;
      logic        ill, ie, pend, ext, tmr, mr, exc, intr;
      logic [31:0] pc, cause;
      logic        cx;
      logic [31:0] base;
      logic [1:0]  mode;
      logic [31:0] mtgt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(logic en, logic [1:0] op, logic [11:0] addr, logic [31:0] wdata,
                              logic crd, logic [31:0] erd, logic ill, logic ie, logic pend,
                              logic ext = 0, logic tmr = 0, logic mr = 0, logic exc = 0,
                              logic intr = 0, logic [31:0] pc = 0, logic [31:0] cause = 0,
                              logic cx = 0, logic [31:0] base = 0, logic [1:0] mode = 0,
                              logic [31:0] mtgt = 0);
      vec_t r;
      r.en = en; r.op = op; r.addr = addr; r.wdata = wdata; r.crd = crd; r.erd = erd;
      r.ill = ill; r.ie = ie; r.pend = pend; r.ext = ext; r.tmr = tmr; r.mr = mr;
      r.exc = exc; r.intr = intr; r.pc = pc; r.cause = cause;
      r.cx = cx; r.base = base; r.mode = mode; r.mtgt = mtgt;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle();
      csr_en = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
      exception = 0; interrupt = 0; exception_pc = 0; exception_cause = 0;
      mret = 0; instret = 0; ext_irq = 0; timer_irq = 0;
   endtask

   task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
      idle();
      csr_en = 1; csr_op = op; csr_addr = addr; csr_wdata = wd;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      idle();
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // first cycle after reset
      csr(0, 12'hB00, 0);
      @(negedge clk);
      check("rst_mcycle0", csr_rdata, 32'd0);
      check("rst_ie", {31'b0, interrupt_en}, 0);
      check("rst_mode", {30'b0, mtvec_mode}, 0);
      check("rst_base", mtvec_base, 0);
      check("rst_mtgt", mret_target, 0);
      check("rst_pend", {31'b0, irq_pending}, 0);
      step();
      @(negedge clk);
      check("rst_mcycle1", csr_rdata, 32'd1);
      step();

      tbl.push_back(v(1,0,'h300,0,1,'h1800,0,0,0));
      tbl.push_back(v(1,0,'h305,0,1,0,0,0,0));
      tbl.push_back(v(1,0,'h341,0,1,0,0,0,0));
      tbl.push_back(v(1,1,'h305,'h80000101,1,0,0,0,0));
      tbl.push_back(v(1,0,'h305,0,1,'h80000101,0,0,0,0,0,0,0,0,0,0,1,'h80000100,1,0));
      tbl.push_back(v(1,1,'h305,'h203,1,'h80000101,0,0,0));
      tbl.push_back(v(1,0,'h305,0,1,'h201,0,0,0,0,0,0,0,0,0,0,1,'h200,1,0));
      tbl.push_back(v(1,2,'h300,8,1,'h1800,0,0,0));
      tbl.push_back(v(1,0,'h300,0,1,'h1808,0,1,0));
      tbl.push_back(v(1,1,'h341,'hDEAD0000,1,0,0,1,0,0,0,0,1,0,'h1236,2));
      tbl.push_back(v(1,0,'h341,0,1,'h1234,0,0,0,0,0,0,0,0,0,0,1,'h200,1,'h1234));
      tbl.push_back(v(1,0,'h342,0,1,2,0,0,0));
      tbl.push_back(v(1,0,'h300,0,1,'h1880,0,0,0));
      tbl.push_back(v(1,0,'h300,0,1,'h1880,0,0,0,0,0,1));
      tbl.push_back(v(1,0,'h300,0,1,'h1888,0,1,0));
      tbl.push_back(v(1,3,'h300,8,1,'h1888,0,1,0,0,0,1));
      tbl.push_back(v(1,0,'h300,0,1,'h1888,0,1,0));
      tbl.push_back(v(1,1,'h340,'h55,1,0,0,1,0,0,0,0,1,1,'h2000,'hB));
      tbl.push_back(v(1,0,'h342,0,1,'h8000000B,0,0,0));
      tbl.push_back(v(1,0,'h340,0,1,'h55,0,0,0));
      tbl.push_back(v(1,0,'h300,0,1,'h1880,0,0,0));
      tbl.push_back(v(1,1,'hC00,5,0,0,1,0,0));
      tbl.push_back(v(1,2,'hC00,0,0,0,0,0,0));
      tbl.push_back(v(1,0,'h7C0,0,1,0,1,0,0));
      tbl.push_back(v(0,1,'h7C0,1,0,0,0,0,0));
      tbl.push_back(v(1,1,'hF14,1,1,0,1,0,0));
      tbl.push_back(v(1,0,'h301,0,1,'h40000100,0,0,0));
      tbl.push_back(v(1,1,'h304,'hFFFFFFFF,1,0,0,0,0));
      tbl.push_back(v(1,0,'h304,0,1,'h880,0,0,0));
      tbl.push_back(v(1,0,'h344,0,1,'h800,0,0,0,1));
      tbl.push_back(v(1,2,'h300,8,1,'h1880,0,0,0,1));
      tbl.push_back(v(1,0,'h344,0,1,'h800,0,1,1,1));
      tbl.push_back(v(1,0,'h344,0,1,'h80,0,1,1,0,1));
      tbl.push_back(v(1,0,'h344,0,1,0,0,1,0));
      tbl.push_back(v(1,3,'h304,'h800,1,'h880,0,1,0));
      tbl.push_back(v(1,0,'h304,0,1,'h80,0,1,0,1));
      tbl.push_back(v(1,1,'h341,'h1003,1,'h2000,0,1,0));
      tbl.push_back(v(1,0,'h341,0,1,'h1000,0,1,0,0,0,0,0,0,0,0,1,'h200,1,'h1000));
      tbl.push_back(v(1,1,'h343,'hABCD,1,0,0,1,0));
      tbl.push_back(v(1,0,'h343,0,1,'hABCD,0,1,0));

      for (int i = 0; i < tbl.size(); i++) begin
         csr_en = tbl[i].en; csr_op = tbl[i].op; csr_addr = tbl[i].addr; csr_wdata = tbl[i].wdata;
         exception = tbl[i].exc; interrupt = tbl[i].intr;
         exception_pc = tbl[i].pc; exception_cause = tbl[i].cause;
         mret = tbl[i].mr; ext_irq = tbl[i].ext; timer_irq = tbl[i].tmr; instret = 0;
         @(negedge clk);
         if (tbl[i].crd) check($sformatf("v%0d_rdata", i), csr_rdata, tbl[i].erd);
         check($sformatf("v%0d_illegal", i), {31'b0, csr_illegal}, {31'b0, tbl[i].ill});
         check($sformatf("v%0d_ie", i), {31'b0, interrupt_en}, {31'b0, tbl[i].ie});
         check($sformatf("v%0d_pend", i), {31'b0, irq_pending}, {31'b0, tbl[i].pend});
         if (tbl[i].cx) begin
            check($sformatf("v%0d_base", i), mtvec_base, tbl[i].base);
            check($sformatf("v%0d_mode", i), {30'b0, mtvec_mode}, {30'b0, tbl[i].mode});
            check($sformatf("v%0d_mtgt", i), mret_target, tbl[i].mtgt);
         end
         step();
      end

      // illegal write to the cycle alias must not disturb mcycle
      csr(1, 12'hB00, 100); step();
      csr(0, 12'hB00, 0); @(negedge clk); check("mcyc_load", csr_rdata, 100); step();
      csr(1, 12'hC00, 5); @(negedge clk); check("cyc_wr_ill", {31'b0, csr_illegal}, 1); step();
      csr(0, 12'hB00, 0); @(negedge clk); check("mcyc_after_ill", csr_rdata, 102); step();

      // low/high writes then carry into mcycleh
      csr(1, 12'hB00, 32'hFFFF_FFFF); step();
      csr(1, 12'hB80, 0); step();
      csr(0, 12'hB80, 0); @(negedge clk); check("mcych_before", csr_rdata, 0); step();
      csr(0, 12'hC80, 0); @(negedge clk); check("mcych_carry", csr_rdata, 1); step();
      csr(0, 12'hB00, 0); @(negedge clk); check("mcyc_low_wrap", csr_rdata, 1); step();

      // minstret: write suppresses increment, then counts only on instret
      csr(1, 12'hB02, 10); instret = 1; step();
      csr(0, 12'hC02, 0); instret = 1; @(negedge clk); check("minst_wr", csr_rdata, 10); step();
      csr(0, 12'hC02, 0); instret = 1; @(negedge clk); check("minst_inc1", csr_rdata, 11); step();
      csr(0, 12'hC02, 0); @(negedge clk); check("minst_inc2", csr_rdata, 12); step();
      csr(0, 12'hB02, 0); @(negedge clk); check("minst_hold", csr_rdata, 12); step();

      // reset beats a concurrent trap and write
      csr(1, 12'h341, 32'h44); exception = 1; exception_pc = 32'h3000; exception_cause = 5;
      rst = 1; step();
      rst = 0;
      csr(0, 12'h341, 0); @(negedge clk);
      check("rst_ovr_mepc", csr_rdata, 0);
      check("rst_ovr_mtgt", mret_target, 0);
      step();
      csr(0, 12'h342, 0); @(negedge clk); check("rst_ovr_mcause", csr_rdata, 0); step();
      csr(0, 12'h300, 0); @(negedge clk); check("rst_ovr_mstatus", csr_rdata, 32'h1800); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
